// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundles the pixel-source and display-side signals of the VGA timing
// generator.
//   master  - timing generator: takes pix_en/pix_rgb/test_mode, drives counters,
//             pix_req and the registered display outputs.
//   slave   - upstream pixel source / display side (mirror of master).
// Parameters: HCNT_W/VCNT_W counter widths, RGB_W colour width.
interface vga_timing_gen_if #(
   parameter int unsigned HCNT_W = 10,
   parameter int unsigned VCNT_W = 10,
   parameter int unsigned RGB_W  = 12
);
   logic              pix_en;
   logic [RGB_W-1:0]  pix_rgb;
   logic              test_mode;
   logic [HCNT_W-1:0] hcount;
   logic [VCNT_W-1:0] vcount;
   logic              pix_req;
   logic              hsync;
   logic              vsync;
   logic              de;
   logic [RGB_W-1:0]  rgb_out;
   logic              frame_start;

   modport master (
      input  pix_en, pix_rgb, test_mode,
      output hcount, vcount, pix_req, hsync, vsync, de, rgb_out, frame_start
   );

   modport slave (
      output pix_en, pix_rgb, test_mode,
      input  hcount, vcount, pix_req, hsync, vsync, de, rgb_out, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator in the clk_in domain. Horizontal/vertical
// counters advance once per pix_en pulse; the current (hcount, vcount) is decoded into
// registered hsync/vsync/de/rgb_out with one pix_en of latency.
// Ports:
//   clk_in, reset     - clock and synchronous active-high reset
//   vga_io (master)   - pix_en, pix_rgb, test_mode in; hcount, vcount, pix_req (comb),
//                       hsync, vsync, de, rgb_out, frame_start out
// Optional feature: define VGA_TEST_PATTERN_EN to build the 8-bar colour pattern selected
// by test_mode. Without it test_mode is ignored. RGB_W must be a multiple of 3.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned RGB_W     = 12
) (
   input logic              clk_in,
   input logic              reset,
   vga_timing_gen_if.master vga_io
);
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW      = $clog2(H_TOTAL);
   localparam int unsigned VCW      = $clog2(V_TOTAL);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [HCW-1:0]   hcount_q, hcount_d;
   logic [VCW-1:0]   vcount_q, vcount_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;

   logic             pix_req;
   logic             in_hsync, in_vsync;
   logic             line_end, frame_end;
   logic [RGB_W-1:0] pix_colour;

   // Sync windows are compared at 32 bits so an end bound equal to 2**HCW cannot wrap.
   always_comb begin
      pix_req   = (32'(hcount_q) < H_ACTIVE) && (32'(vcount_q) < V_ACTIVE);
      in_hsync  = (32'(hcount_q) >= HS_START) && (32'(hcount_q) < HS_END);
      in_vsync  = (32'(vcount_q) >= VS_START) && (32'(vcount_q) < VS_END);
      line_end  = (hcount_q == HCW'(H_TOTAL - 1));
      frame_end = (vcount_q == VCW'(V_TOTAL - 1));
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W   = H_ACTIVE / 8;
   localparam int unsigned FIELD_W = RGB_W / 3;

   logic [2:0] bar_idx;
   logic [2:0] bar_rgb;

   // Bar order white, yellow, cyan, green, magenta, red, blue, black as {r,g,b} bits.
   always_comb begin
      bar_idx = 3'(32'(hcount_q) / BAR_W);
      case (bar_idx)
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase
      if (vga_io.test_mode) begin
         pix_colour = {{FIELD_W{bar_rgb[2]}}, {FIELD_W{bar_rgb[1]}}, {FIELD_W{bar_rgb[0]}}};
      end else begin
         pix_colour = vga_io.pix_rgb;
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = vga_io.test_mode;

   always_comb begin
      pix_colour = vga_io.pix_rgb;
   end
`endif

   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      if (vga_io.pix_en) begin
         // Decode the position the counters hold now, then advance.
         de_d          = pix_req;
         hsync_d       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
         vsync_d       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
         rgb_d         = pix_req ? pix_colour : '0;
         frame_start_d = (hcount_q == '0) && (vcount_q == '0);
         if (line_end) begin
            hcount_d = '0;
            vcount_d = frame_end ? '0 : vcount_q + 1'b1;
         end else begin
            hcount_d = hcount_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_io.hcount      = hcount_q;
   assign vga_io.vcount      = vcount_q;
   assign vga_io.pix_req     = pix_req;
   assign vga_io.hsync       = hsync_q;
   assign vga_io.vsync       = vsync_q;
   assign vga_io.de          = de_q;
   assign vga_io.rgb_out     = rgb_q;
   assign vga_io.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen. dut_a uses the 640x480 defaults; dut_b is a
// small 24x10 raster (active-high hsync) so whole frames and wraps fit in a short run.
// Both share clk/reset/pix_en/pix_rgb/test_mode. Expected outputs are queued per pix_en
// from a position model and popped when the registered outputs update.
module tb_vga_timing_gen;
   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [11:0] rgb;
   } exp_t;

   localparam exp_t RST_A = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 12'h000};
   localparam exp_t RST_B = '{de: 1'b0, hs: 1'b0, vs: 1'b1, fs: 1'b0, rgb: 12'h000};

   logic        clk_in    = 1'b0;
   logic        reset     = 1'b1;
   logic        pix_en    = 1'b0;
   logic        test_mode = 1'b0;
   logic [11:0] pix_rgb   = 12'h000;
   logic        rgb_rand  = 1'b1;

   always #5 clk_in = ~clk_in;

   vga_timing_gen_if #(.HCNT_W(10), .VCNT_W(10), .RGB_W(12)) if_a ();
   vga_timing_gen_if #(.HCNT_W(5), .VCNT_W(4), .RGB_W(12)) if_b ();

   assign if_a.pix_en    = pix_en;
   assign if_a.pix_rgb   = pix_rgb;
   assign if_a.test_mode = test_mode;
   assign if_b.pix_en    = pix_en;
   assign if_b.pix_rgb   = pix_rgb;
   assign if_b.test_mode = test_mode;

   vga_timing_gen dut_a (
      .clk_in (clk_in),
      .reset  (reset),
      .vga_io (if_a.master)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .RGB_W(12)
   ) dut_b (
      .clk_in (clk_in),
      .reset  (reset),
      .vga_io (if_b.master)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t cur_a, cur_b;
   int   h_a = 0, v_a = 0, h_b = 0, v_b = 0;
   logic [11:0] rgb_used;

   int hs_low_a, hs_first_a, hs_last_a, de_a, de_first_a;
   int de_b, vs_low_b, fs_b, rgb_bad_b, blank_bad_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef VGA_TEST_PATTERN_EN
   function automatic logic [11:0] bar_colour(input int idx);
      case (idx)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         5:       return 12'hF00;
         6:       return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction
`endif

   task automatic expect_px(input int ha, input int hfp, input int hsw, input int va,
                            input int vfp, input int vsw, input logic hpol, input logic vpol,
                            input int h, input int v, output exp_t e);
      logic act;
      act   = (h < ha) && (v < va);
      e.de  = act;
      e.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
      e.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
      e.fs  = (h == 0) && (v == 0);
      e.rgb = act ? pix_rgb : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode && act) e.rgb = bar_colour(h / (ha / 8));
`endif
   endtask

   task automatic advance(input int ht, input int vt, inout int h, inout int v);
      if (h == ht - 1) begin
         h = 0;
         v = (v == vt - 1) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
   endtask

   task automatic clear_stats();
      hs_low_a = 0; hs_first_a = -1; hs_last_a = -1; de_a = 0; de_first_a = -1;
      de_b = 0; vs_low_b = 0; fs_b = 0; rgb_bad_b = 0; blank_bad_b = 0;
   endtask

   task automatic check_all();
      chk("a_hcount", 32'(if_a.hcount), 32'(h_a));
      chk("a_vcount", 32'(if_a.vcount), 32'(v_a));
      chk("a_pix_req", 32'(if_a.pix_req), 32'(h_a < 640 && v_a < 480));
      chk("a_outputs", 32'({if_a.de, if_a.hsync, if_a.vsync, if_a.frame_start, if_a.rgb_out}),
          32'(cur_a));
      chk("b_hcount", 32'(if_b.hcount), 32'(h_b));
      chk("b_vcount", 32'(if_b.vcount), 32'(v_b));
      chk("b_pix_req", 32'(if_b.pix_req), 32'(h_b < 16 && v_b < 6));
      chk("b_outputs", 32'({if_b.de, if_b.hsync, if_b.vsync, if_b.frame_start, if_b.rgb_out}),
          32'(cur_b));
   endtask

   // One clk_in cycle: drive at negedge, check 1 time unit after the posedge.
   task automatic cyc(input logic en, input logic rst);
      exp_t e;
      int   ph_a;
      @(negedge clk_in);
      reset  = rst;
      pix_en = en;
      if (rgb_rand) pix_rgb = 12'($urandom);
      rgb_used = pix_rgb;
      ph_a = h_a;
      if (rst) begin
         q_a.delete(); q_b.delete();
         h_a = 0; v_a = 0; h_b = 0; v_b = 0;
      end else if (en) begin
         expect_px(640, 16, 96, 480, 10, 2, 1'b0, 1'b0, h_a, v_a, e);
         q_a.push_back(e);
         advance(800, 525, h_a, v_a);
         expect_px(16, 2, 3, 6, 1, 2, 1'b1, 1'b0, h_b, v_b, e);
         q_b.push_back(e);
         advance(24, 10, h_b, v_b);
      end
      @(posedge clk_in);
      #1;
      if (rst) begin
         cur_a = RST_A;
         cur_b = RST_B;
      end else if (en) begin
         cur_a = q_a.pop_front();
         cur_b = q_b.pop_front();
         if (if_a.hsync === 1'b0) begin
            if (hs_low_a == 0) hs_first_a = ph_a;
            hs_last_a = ph_a;
            hs_low_a++;
         end
         if (if_a.de === 1'b1) begin
            if (de_a == 0) de_first_a = ph_a;
            de_a++;
         end
         if (if_b.de === 1'b1) begin
            de_b++;
            if (if_b.rgb_out !== rgb_used) rgb_bad_b++;
         end else if (if_b.rgb_out !== 12'h000) begin
            blank_bad_b++;
         end
         if (if_b.vsync === 1'b0) vs_low_b++;
         if (if_b.frame_start === 1'b1) fs_b++;
      end else begin
         cur_a.fs = 1'b0;
         cur_b.fs = 1'b0;
      end
      check_all();
   endtask

   initial begin
      int iter;
      clear_stats();

      // Reset held while pix_en toggles.
      for (int i = 0; i < 6; i++) cyc(1'(i % 2), 1'b1);
      chk("rst_a_hsync", 32'(if_a.hsync), 32'd1);
      chk("rst_a_vsync", 32'(if_a.vsync), 32'd1);

      // One default line with pix_en every 4th cycle.
      clear_stats();
      for (int i = 0; i < 800; i++) begin
         cyc(1'b1, 1'b0);
         repeat (3) cyc(1'b0, 1'b0);
      end
      chk("line_hs_low_cnt", 32'(hs_low_a), 32'd96);
      chk("line_hs_first_h", 32'(hs_first_a), 32'd656);
      chk("line_hs_last_h", 32'(hs_last_a), 32'd751);
      chk("line_de_cnt", 32'(de_a), 32'd640);
      chk("line_de_first_h", 32'(de_first_a), 32'd0);

      // Full small frame, continuous pix_en, constant colour.
      cyc(1'b0, 1'b1);
      rgb_rand = 1'b0;
      pix_rgb  = 12'hABC;
      clear_stats();
      for (int i = 0; i < 240; i++) cyc(1'b1, 1'b0);
      chk("frame_de_cnt", 32'(de_b), 32'd96);
      chk("frame_vs_low_cnt", 32'(vs_low_b), 32'd48);
      chk("frame_rgb_bad", 32'(rgb_bad_b), 32'd0);
      chk("frame_blank_bad", 32'(blank_bad_b), 32'd0);
      chk("frame_fs_cnt", 32'(fs_b), 32'd1);
      chk("wrap_b_hcount", 32'(if_b.hcount), 32'd0);
      chk("wrap_b_vcount", 32'(if_b.vcount), 32'd0);
      for (int i = 0; i < 480; i++) cyc(1'b1, 1'b0);
      chk("fs_three_frames", 32'(fs_b), 32'd3);

      // Irregular gaps, then reset mid-frame at (13,4) of the small raster.
      rgb_rand = 1'b1;
      cyc(1'b0, 1'b1);
      iter = 0;
      while (!(h_b == 13 && v_b == 4) && iter < 1000) begin
         cyc(1'b1, 1'b0);
         repeat ($urandom_range(1, 7)) cyc(1'b0, 1'b0);
         iter++;
      end
      chk("gap_reached_pos", 32'(h_b == 13 && v_b == 4), 32'd1);
      cyc(1'b1, 1'b1);
      chk("midrst_b_hcount", 32'(if_b.hcount), 32'd0);
      chk("midrst_b_vcount", 32'(if_b.vcount), 32'd0);
      chk("midrst_b_de", 32'(if_b.de), 32'd0);
      chk("midrst_b_hsync", 32'(if_b.hsync), 32'd0);
      chk("midrst_a_hcount", 32'(if_a.hcount), 32'd0);
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, 1'b0);
         repeat ($urandom_range(1, 7)) cyc(1'b0, 1'b0);
      end

      // test_mode over one default line (bars only when the pattern is built in).
      test_mode = 1'b1;
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 800; i++) cyc(1'b1, 1'b0);
      test_mode = 1'b0;
      for (int i = 0; i < 40; i++) cyc(1'(i % 3 == 0), 1'b0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
